unidade_mult_div: RTL
=====================

UNIDADE_MULT_DIV -- requirements
Module: unidade_mult_div

Interface
REQ-001 The block SHALL have parameter bits_palavra, default 32, setting the operand/result word width.
REQ-002 The block SHALL have parameter end_registros, default 4, setting the destination register address width.
REQ-003 The block SHALL have port clock  input  1  single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port inicia  input  1  start request, sampled only in OCIOSO.
REQ-006 The block SHALL have port operacao  input  2  operation: 00 MUL low word, 01 MUL high word, 10 DIV quotient, 11 DIV remainder (all unsigned).
REQ-007 The block SHALL have ports A and B  input  bits_palavra  operands (dividend/multiplicand A, divisor/multiplier B) from the register bank read ports.
REQ-008 The block SHALL have port end_destino_in  input  end_registros  destination register address.
REQ-009 The block SHALL have port resultado  output  bits_palavra  registered result, drives register bank write data E.
REQ-010 The block SHALL have port end_destino  output  end_registros  registered destination address, drives register bank write address.
REQ-011 The block SHALL have port Habilita  output  1  register bank write enable, one-cycle pulse.
REQ-012 The block SHALL have port ocupado  output  1  high while the block is not in OCIOSO.
REQ-013 The block SHALL have port div_zero  output  1  registered flag: last completed DIV/REM had B = 0.

Function
REQ-014 The FSM SHALL have states OCIOSO, CALCULA, CONCLUI.
REQ-015 In OCIOSO with inicia=1 at a rising edge, the block SHALL latch A, B, operacao, end_destino_in, clear the iteration counter, and enter CALCULA.
REQ-016 Inputs A, B, operacao, end_destino_in SHALL be ignored after acceptance; only latched copies are used.
REQ-017 CALCULA SHALL perform exactly one iteration per cycle for 32 cycles (counter 0..31), then enter CONCLUI.
REQ-018 MUL SHALL use shift-add over a 2*bits_palavra-bit product; op 00 returns bits [31:0], op 01 returns bits [63:32].
REQ-019 DIV/REM SHALL use restoring division; op 10 returns quotient, op 11 returns remainder.
REQ-020 For B = 0 with op 10/11, the result SHALL be quotient 0xFFFFFFFF / remainder = A, div_zero=1, with unchanged latency.
REQ-021 In CONCLUI (one cycle), Habilita SHALL be 1 and resultado/end_destino valid; the next edge SHALL return to OCIOSO with Habilita=0.
REQ-022 Latency SHALL be fixed: inicia accepted at edge t gives Habilita high from edge t+33 to t+34, covering one register bank write edge.
REQ-023 inicia during CALCULA or CONCLUI SHALL be ignored; earliest next acceptance is the edge leaving CONCLUI.
REQ-024 resultado, end_destino and div_zero SHALL hold their values until the next CONCLUI; div_zero SHALL be cleared on a MUL completion.
REQ-025 ocupado SHALL be 1 in CALCULA and CONCLUI, 0 in OCIOSO.

Reset
REQ-026 Reset SHALL force OCIOSO, counter 0, resultado 0, end_destino 0, Habilita 0, ocupado 0, div_zero 0, immediately and independent of clock.
REQ-027 Reset during CALCULA or CONCLUI SHALL abort the operation with no write pulse issued.

Structure
REQ-028 Opcode constants (MUL_L, MUL_H, DIV_Q, DIV_R) and state encodings SHALL live in the shared processor package.
REQ-029 One combinational sub-module, passo_mult_div, SHALL compute a single shift-add or restore-subtract iteration; the FSM, counter and registers stay in unidade_mult_div.

Verification
REQ-030 Reset, then A=7, B=6, op 00, dest 3, inicia at edge t -> Habilita high t+33..t+34, resultado=42, end_destino=3.
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF, op 01 -> resultado=0xFFFFFFFE; op 00 -> resultado=0x00000001.
REQ-032 A=100, B=7: op 10 -> 14, op 11 -> 2, div_zero=0.
REQ-033 A=55, B=0: op 10 -> 0xFFFFFFFF, div_zero=1; op 11 -> 55, div_zero=1; next MUL clears div_zero.
REQ-034 inicia held high continuously with changing A -> only first operands used, accepts exactly every 34 cycles, one Habilita pulse each.
REQ-035 Reset asserted at cycle 10 of CALCULA -> ocupado=0, no Habilita pulse, resultado=0; new inicia afterwards completes normally.

Source files
------------

// File: rtl/unidade_mult_div_pkg.sv
// Shared opcodes and FSM encodings for the iterative multiply/divide unit.
package unidade_mult_div_pkg;

    typedef enum logic [1:0] {
        MUL_L = 2'b00,
        MUL_H = 2'b01,
        DIV_Q = 2'b10,
        DIV_R = 2'b11
    } operacao_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CALCULA = 2'b01,
        CONCLUI = 2'b10
    } estado_t;

    function automatic logic eh_divisao(input operacao_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/unidade_mult_div_if.sv
// Request/response bundle between the issue logic / register bank and the mult/div unit.
interface unidade_mult_div_if #(
    parameter int bits_palavra  = 32,
    parameter int end_registros = 4
);
    logic                     inicia;
    logic [1:0]               operacao;
    logic [bits_palavra-1:0]  A;
    logic [bits_palavra-1:0]  B;
    logic [end_registros-1:0] end_destino_in;
    logic [bits_palavra-1:0]  resultado;
    logic [end_registros-1:0] end_destino;
    logic                     Habilita;
    logic                     ocupado;
    logic                     div_zero;

    modport master (
        output inicia, operacao, A, B, end_destino_in,
        input  resultado, end_destino, Habilita, ocupado, div_zero
    );

    modport slave (
        input  inicia, operacao, A, B, end_destino_in,
        output resultado, end_destino, Habilita, ocupado, div_zero
    );
endinterface

// File: rtl/unidade_mult_div_passo.sv
// One iteration of shift-add multiply or restoring divide on a shared 2W-bit accumulator.
module passo_mult_div #(
    parameter int bits_palavra = 32
) (
    input  logic                      eh_div,
    input  logic [2*bits_palavra-1:0] acc,
    input  logic [bits_palavra-1:0]   operando,
    output logic [2*bits_palavra-1:0] acc_prox
);
    localparam int W = bits_palavra;

    logic [W:0]   soma;
    logic [W:0]   resto_desl;
    logic         cabe;
    logic [W-1:0] resto_novo;

    // MUL: acc = {partial product, remaining multiplier}; DIV: acc = {remainder, dividend/quotient}.
    // The trial result is below the divisor when it fits, so a W-bit subtract is enough.
    always_comb begin
        soma       = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operando} : {(W+1){1'b0}});
        resto_desl = acc[2*W-1:W-1];
        cabe       = resto_desl >= {1'b0, operando};
        resto_novo = cabe ? (resto_desl[W-1:0] - operando) : resto_desl[W-1:0];
        if (eh_div)
            acc_prox = {resto_novo, acc[W-2:0], cabe};
        else
            acc_prox = {soma, acc[W-1:1]};
    end
endmodule

// File: rtl/unidade_mult_div.sv
// Fixed-latency unsigned multiply/divide unit: latches operands, iterates once per cycle,
// then pulses the register bank write enable for one cycle.
module unidade_mult_div
    import unidade_mult_div_pkg::*;
#(
    parameter int bits_palavra  = 32,
    parameter int end_registros = 4
) (
    input  logic clock,
    input  logic reset,
    unidade_mult_div_if.slave bus
);
    localparam int W  = bits_palavra;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(W);

    estado_t                  estado, estado_prox;
    logic [CW-1:0]            contador;
    logic [2*W-1:0]           acc, acc_prox;
    logic [W-1:0]             a_reg, b_reg;
    operacao_t                op_reg;
    logic [end_registros-1:0] dest_reg;
    logic                     aceita, ultimo, div_op;

    assign ultimo = contador == ULTIMO;
    assign div_op = eh_divisao(op_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    // A new request is also taken on the edge leaving CONCLUI so back-to-back ops run every W+2 cycles.
    always_comb begin
        estado_prox = estado;
        aceita      = 1'b0;
        case (estado)
            OCIOSO: if (bus.inicia) begin
                aceita      = 1'b1;
                estado_prox = CALCULA;
            end
            CALCULA: if (ultimo) estado_prox = CONCLUI;
            CONCLUI: begin
                if (bus.inicia) begin
                    aceita      = 1'b1;
                    estado_prox = CALCULA;
                end else begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    passo_mult_div #(.bits_palavra(W)) u_passo (
        .eh_div   (div_op),
        .acc      (acc),
        .operando (div_op ? b_reg : a_reg),
        .acc_prox (acc_prox)
    );

    // Counter runs 0..W-1 doing iterations; the extra count registers the selected result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador        <= '0;
            acc             <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            op_reg          <= MUL_L;
            dest_reg        <= '0;
            bus.resultado   <= '0;
            bus.end_destino <= '0;
            bus.div_zero    <= 1'b0;
        end else if (aceita) begin
            contador <= '0;
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            op_reg   <= operacao_t'(bus.operacao);
            dest_reg <= bus.end_destino_in;
            acc      <= {{W{1'b0}}, bus.operacao[1] ? bus.A : bus.B};
        end else if (estado == CALCULA) begin
            if (!ultimo) begin
                acc      <= acc_prox;
                contador <= contador + 1'b1;
            end else begin
                bus.resultado   <= op_reg[0] ? acc[2*W-1:W] : acc[W-1:0];
                bus.end_destino <= dest_reg;
                bus.div_zero    <= div_op && (b_reg == '0);
            end
        end
    end

    assign bus.Habilita = estado == CONCLUI;
    assign bus.ocupado  = estado != OCIOSO;
endmodule
